// File: rtl/flag_ctrl_pkg.sv
// Shared encodings for the N/V/Z flag sequencing controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package flag_ctrl_pkg;

   // Instruction class as seen at issue
   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_ARITH = 2'd1,
      CLS_LOGIC = 2'd2,
      CLS_RSVD  = 2'd3
   } iss_class_e;

   // Branch condition codes
   typedef enum logic [2:0] {
      CC_NE     = 3'd0,
      CC_EQ     = 3'd1,
      CC_GT     = 3'd2,
      CC_LT     = 3'd3,
      CC_GE     = 3'd4,
      CC_LE     = 3'd5,
      CC_OV     = 3'd6,
      CC_ALWAYS = 3'd7
   } cond_e;

   // Bit positions inside the {N,V,Z} flag vector
   localparam int FLG_N = 2;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 0;

   typedef logic [2:0] flags_t;

   // Branch sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Per-flag write mask for an issuing instruction; reserved class writes nothing
   function automatic flags_t class_mask(input logic [1:0] cls);
      flags_t m;
      m = '0;
      case (cls)
         CLS_ARITH: m = 3'b111;
         CLS_LOGIC: m[FLG_Z] = 1'b1;
         default:   m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Issue, writeback and branch-resolution signals of the flag controller.
// Latency: n/a (signal bundle only).
// Backpressure: iss_ready throttles issue; br_req is held until br_ack.
interface flag_ctrl_if;
   import flag_ctrl_pkg::*;

   logic       iss_valid;
   logic [1:0] iss_class;
   logic       iss_ready;
   logic       wb_valid;
   flags_t     wb_flags;
   logic       br_req;
   logic [2:0] br_cond;
   logic       br_ack;
   logic       br_taken;

   // Pipeline side: decode, writeback and PC logic
   modport master (
      output iss_valid, iss_class, wb_valid, wb_flags, br_req, br_cond,
      input  iss_ready, br_ack, br_taken
   );

   // Flag controller side
   modport slave (
      input  iss_valid, iss_class, wb_valid, wb_flags, br_req, br_cond,
      output iss_ready, br_ack, br_taken
   );

endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO with combinational read data at the head.
// Latency: push visible at head the cycle after write; pop takes effect at the edge.
// Backpressure: push is accepted when not full, or when full with a simultaneous pop.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;
   assign pop_dat = mem[rd_ptr];

   // Storage array; no reset needed, occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/flag_cond_eval.sv
// Evaluates a branch condition code against an {N,V,Z} flag vector.
// Latency: purely combinational.
// Backpressure: none.
module flag_cond_eval
   import flag_ctrl_pkg::*;
(
   input  flags_t     flags,
   input  logic [2:0] cond,
   output logic       taken
);

   logic n, v, z;

   assign n = flags[FLG_N];
   assign v = flags[FLG_V];
   assign z = flags[FLG_Z];

   // Condition decode
   always_comb begin
      taken = 1'b0;
      case (cond_e'(cond))
         CC_NE:     taken = ~z;
         CC_EQ:     taken = z;
         CC_GT:     taken = ~z & ~n;
         CC_LT:     taken = n;
         CC_GE:     taken = ~n;
         CC_LE:     taken = n | z;
         CC_OV:     taken = v;
         CC_ALWAYS: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_ctrl.sv
// Queues flag-write masks at issue, applies them at writeback, resolves branches on the flags.
// Latency: branch ack one cycle after br_req when no writers are pending; flags update at the wb edge.
// Backpressure: iss_ready drops while full (unless a writeback frees a slot), outside IDLE, or under br_req.
// Optional FLAG_BYPASS_EN: resolve a branch from the merged writeback flags when the last writer retires.
module flag_ctrl
   import flag_ctrl_pkg::*;
#(
   parameter int MAX_PEND = 4,
   localparam int PW = $clog2(MAX_PEND + 1)
) (
   input  logic          clk,
   input  logic          rst,
   flag_ctrl_if.slave    bus,
   output flags_t        flags,
   output logic [PW-1:0] pend_cnt,
   output logic          wb_err
);

   state_e state;
   logic   br_ack_q;
   logic   br_taken_q;

   logic   q_full;
   logic   q_empty;
   flags_t q_mask;
   flags_t push_mask;
   logic   is_writer;
   logic   push;
   logic   pop;
   flags_t flags_nxt;
   logic   taken_cur;
   logic   res_now;
   logic   res_taken;

   assign push_mask = class_mask(bus.iss_class);
   assign is_writer = (push_mask != '0);

   // A pending branch blocks issue so the writer queue can drain
   assign bus.iss_ready = (state == IDLE) & ~bus.br_req & (~q_full | bus.wb_valid);
   assign push          = bus.iss_valid & bus.iss_ready & is_writer;
   assign pop           = bus.wb_valid & ~q_empty;

   assign bus.br_ack   = br_ack_q;
   assign bus.br_taken = br_taken_q;

   fifo #(
      .WIDTH (3),
      .DEPTH (MAX_PEND)
   ) u_mask_q (
      .clk      (clk),
      .rst_n    (rst),
      .push     (push),
      .push_dat (push_mask),
      .pop      (pop),
      .pop_dat  (q_mask),
      .full     (q_full),
      .empty    (q_empty),
      .count    (pend_cnt)
   );

   // Merge the writeback result into the flags under the oldest queued mask
   always_comb begin
      flags_nxt = flags;
      if (pop) begin
         flags_nxt = (flags & ~q_mask) | (bus.wb_flags & q_mask);
      end
   end

   flag_cond_eval u_eval_cur (
      .flags (flags),
      .cond  (bus.br_cond),
      .taken (taken_cur)
   );

`ifdef FLAG_BYPASS_EN
   logic taken_nxt;

   flag_cond_eval u_eval_nxt (
      .flags (flags_nxt),
      .cond  (bus.br_cond),
      .taken (taken_nxt)
   );

   // Resolve now if nothing is pending, or if the last writer retires this cycle
   always_comb begin
      res_now   = (pend_cnt == '0);
      res_taken = taken_cur;
      if ((pend_cnt == PW'(1)) && pop) begin
         res_now   = 1'b1;
         res_taken = taken_nxt;
      end
   end
`else
   // Resolve only once every older writer has retired into the registered flags
   always_comb begin
      res_now   = (pend_cnt == '0);
      res_taken = taken_cur;
   end
`endif

   // Architectural flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags <= '0;
      end else begin
         flags <= flags_nxt;
      end
   end

   // Sticky error for a writeback with no queued writer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_err <= 1'b0;
      end else if (bus.wb_valid && q_empty) begin
         wb_err <= 1'b1;
      end
   end

   // Branch sequencer with registered ack and taken outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         br_ack_q   <= 1'b0;
         br_taken_q <= 1'b0;
      end else begin
         br_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.br_req) begin
                  if (res_now) begin
                     br_taken_q <= res_taken;
                     br_ack_q   <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (res_now) begin
                  br_taken_q <= res_taken;
                  br_ack_q   <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed self-checking bench for flag_ctrl.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: iss_ready checked directly against hand-derived values.
module tb_flag_ctrl;
   import flag_ctrl_pkg::*;

   localparam int MAX_PEND = 4;
   localparam int PW = $clog2(MAX_PEND + 1);

   logic          clk = 1'b0;
   logic          rst;
   flags_t        flags;
   logic [PW-1:0] pend_cnt;
   logic          wb_err;

   int n_chk  = 0;
   int n_pass = 0;

   logic [2:0] cc_tab  [8];
   logic       exp_tab [8];

   flag_ctrl_if bus ();

   flag_ctrl #(.MAX_PEND(MAX_PEND)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .flags    (flags),
      .pend_cnt (pend_cnt),
      .wb_err   (wb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b0;
      bus.iss_valid = 1'b0;
      bus.iss_class = CLS_NONE;
      bus.wb_valid  = 1'b0;
      bus.wb_flags  = 3'b000;
      bus.br_req    = 1'b0;
      bus.br_cond   = CC_ALWAYS;

      // With flags = 111: N=1 V=1 Z=1
      cc_tab[0] = CC_ALWAYS; exp_tab[0] = 1'b1;
      cc_tab[1] = CC_EQ;     exp_tab[1] = 1'b1;
      cc_tab[2] = CC_NE;     exp_tab[2] = 1'b0;
      cc_tab[3] = CC_LT;     exp_tab[3] = 1'b1;
      cc_tab[4] = CC_GT;     exp_tab[4] = 1'b0;
      cc_tab[5] = CC_LE;     exp_tab[5] = 1'b1;
      cc_tab[6] = CC_OV;     exp_tab[6] = 1'b1;
      cc_tab[7] = CC_GE;     exp_tab[7] = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_flags", 32'(flags), 32'h0);
      check("rst_pend", 32'(pend_cnt), 32'h0);
      check("rst_ack", 32'(bus.br_ack), 32'h0);
      check("rst_taken", 32'(bus.br_taken), 32'h0);
      check("rst_wberr", 32'(wb_err), 32'h0);
      check("rst_ready", 32'(bus.iss_ready), 32'h1);
      rst = 1'b1;
      tick();

      // Unconditional branch with nothing pending: ack next cycle
      bus.br_req  = 1'b1;
      bus.br_cond = CC_ALWAYS;
      #1;
      check("br_blocks_issue", 32'(bus.iss_ready), 32'h0);
      tick();
      check("br0_ack", 32'(bus.br_ack), 32'h1);
      check("br0_taken", 32'(bus.br_taken), 32'h1);
      check("br0_flags", 32'(flags), 32'h0);
      bus.br_req = 1'b0;
      tick();
      check("br0_ack_drop", 32'(bus.br_ack), 32'h0);
      check("br0_taken_hold", 32'(bus.br_taken), 32'h1);

      // Arith writer then logic writer
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_ARITH;
      tick();
      check("arith_push", 32'(pend_cnt), 32'h1);
      bus.iss_valid = 1'b0;
      bus.wb_valid  = 1'b1;
      bus.wb_flags  = 3'b110;
      tick();
      check("arith_flags", 32'(flags), 32'h6);
      check("arith_pop", 32'(pend_cnt), 32'h0);
      bus.wb_valid  = 1'b0;
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_LOGIC;
      tick();
      bus.iss_valid = 1'b0;
      bus.wb_valid  = 1'b1;
      bus.wb_flags  = 3'b001;
      tick();
      check("logic_flags", 32'(flags), 32'h7);
      bus.wb_valid  = 1'b0;

      // Non-writing classes never enqueue
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_NONE;
      tick();
      check("cls0_nopush", 32'(pend_cnt), 32'h0);
      bus.iss_class = CLS_RSVD;
      tick();
      check("cls3_nopush", 32'(pend_cnt), 32'h0);
      bus.iss_valid = 1'b0;

      // Every condition code against flags = 111
      for (int i = 0; i < 8; i++) begin
         bus.br_req  = 1'b1;
         bus.br_cond = cc_tab[i];
         tick();
         check($sformatf("cc%0d_ack", cc_tab[i]), 32'(bus.br_ack), 32'h1);
         check($sformatf("cc%0d_taken", cc_tab[i]), 32'(bus.br_taken), 32'(exp_tab[i]));
         bus.br_req = 1'b0;
         tick();
      end

      // Branch waits behind two arith writers
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_ARITH;
      tick();
      tick();
      bus.iss_valid = 1'b0;
      check("wait_pend2", 32'(pend_cnt), 32'h2);
      bus.br_req  = 1'b1;
      bus.br_cond = CC_EQ;
      #1;
      check("wait_ready", 32'(bus.iss_ready), 32'h0);
      tick();
      check("wait_no_ack0", 32'(bus.br_ack), 32'h0);
      bus.wb_valid = 1'b1;
      bus.wb_flags = 3'b000;
      tick();
      check("wait_pend1", 32'(pend_cnt), 32'h1);
      check("wait_no_ack1", 32'(bus.br_ack), 32'h0);
      bus.wb_flags = 3'b001;
      tick();
      bus.wb_valid = 1'b0;
      check("wait_pend0", 32'(pend_cnt), 32'h0);
      check("wait_flags", 32'(flags), 32'h1);
`ifdef FLAG_BYPASS_EN
      check("bypass_ack", 32'(bus.br_ack), 32'h1);
      check("bypass_taken", 32'(bus.br_taken), 32'h1);
`else
      check("wait_no_ack2", 32'(bus.br_ack), 32'h0);
      tick();
      check("wait_ack", 32'(bus.br_ack), 32'h1);
      check("wait_taken", 32'(bus.br_taken), 32'h1);
`endif
      bus.br_req = 1'b0;
      tick();
      check("wait_ack_drop", 32'(bus.br_ack), 32'h0);

      // Fill the queue, then push and pop in the same cycle
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_ARITH;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      check("full_pend", 32'(pend_cnt), 32'h4);
      check("full_ready", 32'(bus.iss_ready), 32'h0);
      bus.wb_valid = 1'b1;
      bus.wb_flags = 3'b010;
      #1;
      check("full_wb_ready", 32'(bus.iss_ready), 32'h1);
      tick();
      check("full_swap_pend", 32'(pend_cnt), 32'h4);
      check("full_swap_flags", 32'(flags), 32'h2);
      bus.iss_valid = 1'b0;
      bus.wb_flags  = 3'b100;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      bus.wb_valid = 1'b0;
      check("drain_pend", 32'(pend_cnt), 32'h0);
      check("drain_flags", 32'(flags), 32'h4);
      check("drain_wberr", 32'(wb_err), 32'h0);

      // Writeback with empty queue
      bus.wb_valid = 1'b1;
      bus.wb_flags = 3'b011;
      tick();
      bus.wb_valid = 1'b0;
      check("err_set", 32'(wb_err), 32'h1);
      check("err_flags", 32'(flags), 32'h4);
      tick();
      tick();
      check("err_sticky", 32'(wb_err), 32'h1);

      // Async reset while a branch waits
      bus.iss_valid = 1'b1;
      bus.iss_class = CLS_ARITH;
      tick();
      bus.iss_valid = 1'b0;
      bus.br_req    = 1'b1;
      bus.br_cond   = CC_ALWAYS;
      tick();
      check("arst_wait_ack", 32'(bus.br_ack), 32'h0);
      #3;
      rst = 1'b0;
      #1;
      check("arst_flags", 32'(flags), 32'h0);
      check("arst_pend", 32'(pend_cnt), 32'h0);
      check("arst_wberr", 32'(wb_err), 32'h0);
      check("arst_taken", 32'(bus.br_taken), 32'h0);
      check("arst_ack", 32'(bus.br_ack), 32'h0);
      bus.br_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("post_arst_ack0", 32'(bus.br_ack), 32'h0);
      tick();
      check("post_arst_ack1", 32'(bus.br_ack), 32'h0);
      check("post_arst_ready", 32'(bus.iss_ready), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
